fetch_unit: RTL

Instruction fetch stage for the MIPS core, directly upstream of the controller and datapath. Holds the program counter and fetches one word per instruction from a variable-latency instruction memory over a req/ready handshake. Presents the held instruction to the controller and computes the next PC from the controller's branch/jump decision and the ALU zero flag. A wait-cycle watchdog halts the stage on a hung memory.

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches one word per instruction over a
// req/ready handshake, computes the next PC and halts on a hung memory.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic        jump,
  input  logic        zero,
  input  logic        stall,
  output logic        fetch_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a word is accepted on a rising edge where imem_req and imem_ready
  // are both high; imem_ready is ignored while imem_req is low.

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            err_q, err_d;

  logic [CW-1:0]   wait_inc;
  logic [31:0]     jump_tgt;
  logic [31:0]     br_off;
  logic [31:0]     next_pc;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Jump keeps the region bits of pc+4; branch offset is a signed word count.
  always_comb begin
    jump_tgt = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    if (jump) begin
      next_pc = jump_tgt;
    end else if (branch && zero) begin
      next_pc = pc_plus4 + br_off;
    end else begin
      next_pc = pc_plus4;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    wait_d   = wait_q;
    err_d    = err_q;
    wait_inc = wait_q + CW'(1);
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          // Ready wins even on the edge the counter would hit its limit.
          instr_d = imem_rdata;
          wait_d  = '0;
          state_d = S_ISSUE;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_LIMIT) begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    imem_req    = (state_q == S_FETCH);
    instr_valid = (state_q == S_ISSUE);
    imem_addr   = pc_q;
    pc          = pc_q;
    pc_plus4    = pc_q + 32'd4;
    instr       = instr_q;
    fetch_err   = err_q;
    dbg_state   = state_q;
  end

endmodule
